// File: rtl/hazard_fwd_unit_if.sv
// rtl/hazard_fwd_unit_if.sv - decode-stage / hazard unit signal bundle
interface hazard_fwd_unit_if #(parameter int REGW = 5);
  logic [REGW-1:0] id_rs1;
  logic [REGW-1:0] id_rs2;
  logic            id_rs1_fp;
  logic            id_rs2_fp;
  logic            id_use1;
  logic            id_use2;
  logic            id_branch;
  logic [REGW-1:0] id_destreg;
  logic            id_dest_fp;
  logic            id_regwrite;
  logic            id_load;
  logic            ctl_taken;
  logic            flush;
  logic            stall;
  logic            squash;
  logic [1:0]      aluselectA;
  logic [1:0]      aluselectB;

  modport master (
    output id_rs1, id_rs2, id_rs1_fp, id_rs2_fp, id_use1, id_use2, id_branch,
           id_destreg, id_dest_fp, id_regwrite, id_load, ctl_taken, flush,
    input  stall, squash, aluselectA, aluselectB
  );

  modport slave (
    input  id_rs1, id_rs2, id_rs1_fp, id_rs2_fp, id_use1, id_use2, id_branch,
           id_destreg, id_dest_fp, id_regwrite, id_load, ctl_taken, flush,
    output stall, squash, aluselectA, aluselectB
  );
endinterface

// File: rtl/hazard_fwd_unit.sv
// rtl/hazard_fwd_unit.sv - decode-stage stall, squash and forwarding-select control
module hazard_fwd_unit #(
  parameter bit DELAY_SLOT = 1'b1,
  parameter int REGW       = 5
) (
  input logic               clk,
  input logic               reset,
  hazard_fwd_unit_if.slave  hif
);

  typedef struct packed {
    logic            valid;
    logic [REGW-1:0] dest;
    logic            fp;
    logic            load;
  } slot_t;

  slot_t ex_q;
  slot_t mem_q;

  logic ex_v, mem_v, ex_zero, mem_zero;
  logic m_ex1, m_ex2, m_mem1, m_mem2;
  logic load_stall, br_stall, stall_c;

  // Slots are masked during reset so the reset cycle already looks empty.
  assign ex_v     = ex_q.valid & ~reset;
  assign mem_v    = mem_q.valid & ~reset;
  assign ex_zero  = (ex_q.dest == '0) & ~ex_q.fp;
  assign mem_zero = (mem_q.dest == '0) & ~mem_q.fp;

  assign m_ex1  = hif.id_use1 & ex_v & (ex_q.dest == hif.id_rs1) &
                  (ex_q.fp == hif.id_rs1_fp) & ~ex_zero;
  assign m_ex2  = hif.id_use2 & ex_v & (ex_q.dest == hif.id_rs2) &
                  (ex_q.fp == hif.id_rs2_fp) & ~ex_zero;
  assign m_mem1 = hif.id_use1 & mem_v & (mem_q.dest == hif.id_rs1) &
                  (mem_q.fp == hif.id_rs1_fp) & ~mem_zero;
  assign m_mem2 = hif.id_use2 & mem_v & (mem_q.dest == hif.id_rs2) &
                  (mem_q.fp == hif.id_rs2_fp) & ~mem_zero;

  // The branch compare in ID cannot wait for an EX-stage ALU result.
  assign load_stall = (m_ex1 | m_ex2) & ex_q.load;
  assign br_stall   = hif.id_branch & m_ex1 & ~ex_q.load;
  assign stall_c    = load_stall | br_stall;

  assign hif.stall  = stall_c;
  assign hif.squash = ~reset &
                      (hif.flush | (~DELAY_SLOT & hif.ctl_taken & ~stall_c));

  always_comb begin
    hif.aluselectA = 2'd0;
    hif.aluselectB = 2'd0;
    if (m_ex1)       hif.aluselectA = ex_q.load ? 2'd0 : 2'd1;
    else if (m_mem1) hif.aluselectA = 2'd2;
    if (m_ex2)       hif.aluselectB = ex_q.load ? 2'd0 : 2'd1;
    else if (m_mem2) hif.aluselectB = 2'd2;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q  <= '0;
      mem_q <= '0;
    end else begin
      mem_q <= ex_q;
      if (stall_c || hif.flush) begin
        ex_q <= '0;
      end else begin
        ex_q.valid <= hif.id_regwrite;
        ex_q.dest  <= hif.id_destreg;
        ex_q.fp    <= hif.id_dest_fp;
        ex_q.load  <= hif.id_load;
      end
    end
  end

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// tb/tb_hazard_fwd_unit.sv - directed self-checking bench for hazard_fwd_unit
module tb_hazard_fwd_unit;
  logic clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  hazard_fwd_unit_if #(.REGW(5)) hif0 ();
  hazard_fwd_unit_if #(.REGW(5)) hif1 ();

  hazard_fwd_unit #(.DELAY_SLOT(1'b0), .REGW(5)) dut0 (.clk(clk), .reset(reset), .hif(hif0));
  hazard_fwd_unit #(.DELAY_SLOT(1'b1), .REGW(5)) dut1 (.clk(clk), .reset(reset), .hif(hif1));

  assign hif1.id_rs1      = hif0.id_rs1;
  assign hif1.id_rs2      = hif0.id_rs2;
  assign hif1.id_rs1_fp   = hif0.id_rs1_fp;
  assign hif1.id_rs2_fp   = hif0.id_rs2_fp;
  assign hif1.id_use1     = hif0.id_use1;
  assign hif1.id_use2     = hif0.id_use2;
  assign hif1.id_branch   = hif0.id_branch;
  assign hif1.id_destreg  = hif0.id_destreg;
  assign hif1.id_dest_fp  = hif0.id_dest_fp;
  assign hif1.id_regwrite = hif0.id_regwrite;
  assign hif1.id_load     = hif0.id_load;
  assign hif1.ctl_taken   = hif0.ctl_taken;
  assign hif1.flush       = hif0.flush;

  task automatic clear_id();
    hif0.id_rs1 = 5'd0;      hif0.id_rs2 = 5'd0;
    hif0.id_rs1_fp = 1'b0;   hif0.id_rs2_fp = 1'b0;
    hif0.id_use1 = 1'b0;     hif0.id_use2 = 1'b0;
    hif0.id_branch = 1'b0;   hif0.id_destreg = 5'd0;
    hif0.id_dest_fp = 1'b0;  hif0.id_regwrite = 1'b0;
    hif0.id_load = 1'b0;     hif0.ctl_taken = 1'b0;
    hif0.flush = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic produce(input logic [4:0] d, input logic fp, input logic ld);
    clear_id();
    hif0.id_destreg = d; hif0.id_dest_fp = fp; hif0.id_load = ld; hif0.id_regwrite = 1'b1;
  endtask

  task automatic drain();
    clear_id();
    tick(); tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clear_id();
    tick(); tick();
    hif0.flush = 1'b1; hif0.ctl_taken = 1'b1;
    settle();
    tests++;
    if (hif0.stall !== 1'b0 || hif0.squash !== 1'b0 || hif0.aluselectA !== 2'd0 || hif0.aluselectB !== 2'd0) begin
      fails++;
      $display("FAIL reset_outputs: stall=%b squash=%b A=%0d B=%0d required 0 0 0 0",
               hif0.stall, hif0.squash, hif0.aluselectA, hif0.aluselectB);
    end
    clear_id();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_ex_fwd();
    produce(5'd3, 1'b0, 1'b0);
    tick();
    clear_id(); hif0.id_rs1 = 5'd3; hif0.id_use1 = 1'b1;
    settle();
    tests++;
    if (hif0.aluselectA !== 2'd1 || hif0.stall !== 1'b0) begin
      fails++;
      $display("FAIL ex_fwd: A=%0d stall=%b required A=1 stall=0", hif0.aluselectA, hif0.stall);
    end
    drain();
  endtask

  task automatic test_mem_fwd();
    produce(5'd3, 1'b0, 1'b0);
    tick();
    produce(5'd9, 1'b0, 1'b0);
    tick();
    clear_id(); hif0.id_rs2 = 5'd3; hif0.id_use2 = 1'b1; hif0.id_rs1 = 5'd8; hif0.id_use1 = 1'b1;
    settle();
    tests++;
    if (hif0.aluselectB !== 2'd2 || hif0.aluselectA !== 2'd0) begin
      fails++;
      $display("FAIL mem_fwd: A=%0d B=%0d required A=0 B=2", hif0.aluselectA, hif0.aluselectB);
    end
    drain();
  endtask

  task automatic test_load_use();
    produce(5'd5, 1'b0, 1'b1);
    tick();
    clear_id(); hif0.id_rs1 = 5'd5; hif0.id_use1 = 1'b1; hif0.id_regwrite = 1'b1; hif0.id_destreg = 5'd6;
    settle();
    tests++;
    if (hif0.stall !== 1'b1 || hif0.aluselectA !== 2'd0) begin
      fails++;
      $display("FAIL load_use_stall: stall=%b A=%0d required stall=1 A=0", hif0.stall, hif0.aluselectA);
    end
    tick();
    tests++;
    if (hif0.stall !== 1'b0 || hif0.aluselectA !== 2'd2) begin
      fails++;
      $display("FAIL load_use_release: stall=%b A=%0d required stall=0 A=2", hif0.stall, hif0.aluselectA);
    end
    tick();
    // The stalled consumer wrote r6; the bubble must not have carried it, so it is now in EX only.
    clear_id(); hif0.id_rs1 = 5'd6; hif0.id_use1 = 1'b1;
    settle();
    tests++;
    if (hif0.aluselectA !== 2'd1) begin
      fails++;
      $display("FAIL load_use_bubble: A=%0d required 1", hif0.aluselectA);
    end
    drain();
  endtask

  task automatic test_reg_class();
    produce(5'd0, 1'b0, 1'b0);
    tick();
    clear_id(); hif0.id_rs1 = 5'd0; hif0.id_use1 = 1'b1; hif0.id_rs2 = 5'd0; hif0.id_use2 = 1'b1;
    settle();
    tests++;
    if (hif0.aluselectA !== 2'd0 || hif0.aluselectB !== 2'd0) begin
      fails++;
      $display("FAIL r0_nomatch: A=%0d B=%0d required 0 0", hif0.aluselectA, hif0.aluselectB);
    end
    drain();
    produce(5'd0, 1'b1, 1'b0);
    tick();
    clear_id(); hif0.id_rs1 = 5'd0; hif0.id_rs1_fp = 1'b1; hif0.id_use1 = 1'b1;
    settle();
    tests++;
    if (hif0.aluselectA !== 2'd1) begin
      fails++;
      $display("FAIL f0_match: A=%0d required 1", hif0.aluselectA);
    end
    drain();
    produce(5'd7, 1'b0, 1'b0);
    tick();
    clear_id(); hif0.id_rs2 = 5'd7; hif0.id_rs2_fp = 1'b1; hif0.id_use2 = 1'b1;
    settle();
    tests++;
    if (hif0.aluselectB !== 2'd0) begin
      fails++;
      $display("FAIL class_mismatch: B=%0d required 0", hif0.aluselectB);
    end
    hif0.id_use2 = 1'b0; hif0.id_rs2_fp = 1'b0;
    settle();
    tests++;
    if (hif0.aluselectB !== 2'd0) begin
      fails++;
      $display("FAIL use_gating: B=%0d required 0", hif0.aluselectB);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    produce(5'd4, 1'b0, 1'b0);
    tick();
    produce(5'd4, 1'b0, 1'b0);
    tick();
    clear_id(); hif0.id_rs1 = 5'd4; hif0.id_use1 = 1'b1; hif0.id_rs2 = 5'd4; hif0.id_use2 = 1'b1;
    settle();
    tests++;
    if (hif0.aluselectA !== 2'd1 || hif0.aluselectB !== 2'd1) begin
      fails++;
      $display("FAIL ex_priority: A=%0d B=%0d required 1 1", hif0.aluselectA, hif0.aluselectB);
    end
    drain();
  endtask

  task automatic test_branch();
    produce(5'd6, 1'b0, 1'b0);
    tick();
    clear_id(); hif0.id_rs1 = 5'd6; hif0.id_use1 = 1'b1; hif0.id_branch = 1'b1;
    settle();
    tests++;
    if (hif0.stall !== 1'b1) begin
      fails++;
      $display("FAIL branch_stall: stall=%b required 1", hif0.stall);
    end
    tick();
    tests++;
    if (hif0.stall !== 1'b0 || hif0.aluselectA !== 2'd2) begin
      fails++;
      $display("FAIL branch_release: stall=%b A=%0d required stall=0 A=2", hif0.stall, hif0.aluselectA);
    end
    drain();
  endtask

  task automatic test_squash();
    clear_id(); hif0.ctl_taken = 1'b1; hif0.id_branch = 1'b1;
    settle();
    tests++;
    if (hif0.squash !== 1'b1 || hif1.squash !== 1'b0) begin
      fails++;
      $display("FAIL taken_squash: ds0=%b ds1=%b required 1 0", hif0.squash, hif1.squash);
    end
    tick();
    clear_id();
    settle();
    tests++;
    if (hif0.squash !== 1'b0) begin
      fails++;
      $display("FAIL squash_one_cycle: squash=%b required 0", hif0.squash);
    end
    drain();
    produce(5'd5, 1'b0, 1'b1);
    tick();
    clear_id(); hif0.id_rs1 = 5'd5; hif0.id_use1 = 1'b1; hif0.id_branch = 1'b1; hif0.ctl_taken = 1'b1;
    settle();
    tests++;
    if (hif0.stall !== 1'b1 || hif0.squash !== 1'b0) begin
      fails++;
      $display("FAIL stalled_branch: stall=%b squash=%b required 1 0", hif0.stall, hif0.squash);
    end
    tick();
    tests++;
    if (hif0.stall !== 1'b0 || hif0.squash !== 1'b1 || hif0.aluselectA !== 2'd2) begin
      fails++;
      $display("FAIL branch_after_stall: stall=%b squash=%b A=%0d required 0 1 2",
               hif0.stall, hif0.squash, hif0.aluselectA);
    end
    drain();
  endtask

  task automatic test_flush();
    produce(5'd2, 1'b0, 1'b0);
    tick();
    produce(5'd3, 1'b0, 1'b0); hif0.flush = 1'b1;
    settle();
    tests++;
    if (hif0.squash !== 1'b1 || hif1.squash !== 1'b1) begin
      fails++;
      $display("FAIL flush_squash: ds0=%b ds1=%b required 1 1", hif0.squash, hif1.squash);
    end
    tick();
    clear_id(); hif0.id_rs1 = 5'd3; hif0.id_use1 = 1'b1; hif0.id_rs2 = 5'd2; hif0.id_use2 = 1'b1;
    settle();
    tests++;
    if (hif0.aluselectA !== 2'd0 || hif0.aluselectB !== 2'd2) begin
      fails++;
      $display("FAIL flush_slots: A=%0d B=%0d required A=0 B=2", hif0.aluselectA, hif0.aluselectB);
    end
    drain();
  endtask

  task automatic test_reset_mid_stall();
    produce(5'd5, 1'b0, 1'b1);
    tick();
    clear_id(); hif0.id_rs1 = 5'd5; hif0.id_use1 = 1'b1;
    settle();
    tests++;
    if (hif0.stall !== 1'b1) begin
      fails++;
      $display("FAIL pre_reset_stall: stall=%b required 1", hif0.stall);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    settle();
    tests++;
    if (hif0.stall !== 1'b0 || hif0.aluselectA !== 2'd0) begin
      fails++;
      $display("FAIL reset_mid_stall: stall=%b A=%0d required 0 0", hif0.stall, hif0.aluselectA);
    end
    drain();
  endtask

  initial begin
    reset = 1'b1;
    clear_id();
    test_reset();
    test_ex_fwd();
    test_mem_fwd();
    test_load_use();
    test_reg_class();
    test_back_to_back();
    test_branch();
    test_squash();
    test_flush();
    test_reset_mid_stall();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/hazard_fwd_unit.md
Name: hazard_fwd_unit

Overview:
- Pipeline control block paired with the decode stage.
- Consumes the decode stage's register-use and control info, and tracks in-flight destination registers in shadow EX/MEM slots.
- Drives the decode stage's stall, squash and forwarding selects (aluselectA/aluselectB).
- The WB-stage producer is covered by the regfile write bypass, so this unit never selects it.

Parameters:
- DELAY_SLOT, 1: 1 = taken branch/jump executes its delay slot, so no squash; 0 = squash the fetched instruction on a taken transfer.
- REGW, 5: register specifier width.

Ports:
- clk  in  1  pipeline clock
- reset  in  1  synchronous, active-high reset
- id_rs1, id_rs2  in  REGW  source specifiers of the instruction in ID
- id_rs1_fp, id_rs2_fp  in  1  source register class (0 int, 1 fp)
- id_use1, id_use2  in  1  instruction actually reads rs1 / rs2
- id_branch  in  1  ID holds a conditional branch or register jump (compares fwdbusA in ID)
- id_destreg  in  REGW  destination of the ID instruction
- id_dest_fp  in  1  destination class
- id_regwrite  in  1  ID instruction writes a register
- id_load  in  1  ID instruction is a load (mem2reg)
- ctl_taken  in  1  branch taken or jump in ID this cycle
- flush  in  1  external flush request
- stall  out  1  hold IF/ID registers
- squash  out  1  turn the IDRegister contents into nop at the next edge
- aluselectA, aluselectB  out  2  forwarding selects: 0 = regfile, 1 = priorALUresult (EX producer), 2 = ALUwriteback (MEM producer); 3 is never driven

Behaviour:
- Shadow slots EX and MEM each hold {valid, dest, fp, load}, registered on posedge clk.
- Each normal cycle: MEM <= EX; EX <= ID info, valid = id_regwrite.
- On stall: MEM <= EX; EX <= bubble (valid = 0).
- Reset (synchronous): both slots invalid; squash register cleared.
  - During the reset cycle, combinational outputs reflect the invalid slots: stall = 0, selects = 0, squash = 0.
- Match rule, per source n: match_X_n = id_use_n & X.valid & (X.dest == id_rs_n) & (X.fp == id_rs_n_fp) & ~(X.dest == 0 & ~X.fp).
  - Integer r0 never matches.
- Select per source:
  - match_EX & ~EX.load gives 1.
  - Otherwise, match_MEM gives 2.
  - Otherwise 0.
  - EX has priority over MEM, so the youngest producer wins.
- Load-use: match_EX & EX.load on either source forces stall = 1; that source's select is 0.
  - Next cycle the load sits in MEM, so select = 2 and stall clears. Exactly 1 stall cycle.
- Branch rule: id_branch & match_EX_1 with a non-load producer also stalls 1 cycle (the ALU result is too late for the ID compare).
  - Next cycle: select 2.
- Load feeding a branch: 1 stall (load in EX), then forwarding from MEM.
- Squash:
  - squash = flush | (~DELAY_SLOT & ctl_taken & ~stall).
  - Combinational, sampled by IDRegister at the edge.
  - A stalled branch does not squash until the stall clears.
- Simultaneous squash and stall: squash wins inside IDRegister; the unit still inserts an EX bubble.
- flush: also invalidates the EX slot at the edge. MEM advances normally, because the instruction already in MEM is committed.
- Outputs are combinational from the slots plus ID inputs; the slots give 1-cycle memory.
- No X propagation: all slot fields are reset.

Test Plan:
- Reset, then ALU write r3 followed by ADD reading r3 as rs1 -> aluselectA = 1 the cycle the consumer is in ID, stall = 0.
- Producer r3, one independent instruction, consumer of r3 as rs2 -> aluselectB = 2, aluselectA = 0.
- Load r5 followed by a use of r5 -> stall = 1 for exactly 1 cycle with aluselectA = 0, then aluselectA = 2, stall = 0. The EX slot holds the bubble.
- Write to r0, then read r0 -> selects stay 0. fp f0 written then read as fp -> select = 1. int r7 written, fp f7 read -> select 0.
- Back-to-back writes of r4 (ALU, ALU), then read r4 -> select 1, proving EX priority over MEM.
- DELAY_SLOT = 0, ctl_taken = 1 with no hazard -> squash = 1 for 1 cycle.
  - Same branch with a load-use on rs1 -> cycle 1: stall = 1, squash = 0; cycle 2: squash = 1.
  - flush = 1 -> squash = 1 and the EX slot is invalid next cycle.
  - reset asserted mid-stall -> stall = 0 and selects = 0 from the next cycle.
